// File: rtl/angle_reducer_pkg.sv
// Shared constants and state encoding for the angle reduction front end.
package angle_reducer_pkg;

  localparam int AR_DATA_WIDTH = 32;

  localparam int ANGLE_90  = 90;
  localparam int ANGLE_180 = 180;
  localparam int ANGLE_270 = 270;
  localparam int ANGLE_360 = 360;

  typedef enum logic [1:0] {
    AR_IDLE   = 2'd0,
    AR_REDUCE = 2'd1,
    AR_MAP    = 2'd2,
    AR_DONE   = 2'd3
  } ar_state_e;

endpackage

// File: rtl/angle_reducer.sv
// Reduces a signed whole-degree angle modulo 360 by fixed-length shift-subtract,
// then folds it into a 0..90 reference angle plus quadrant for the trig LUTs.
module angle_reducer
  import angle_reducer_pkg::*;
#(
  parameter int DATA_WIDTH = AR_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] angle_in,
  input  logic                  angle_neg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            quadrant,
  output logic [DATA_WIDTH-1:0] angle_out
);

  localparam int KW = $clog2(DATA_WIDTH);
  localparam logic [KW-1:0] K_INIT = KW'(DATA_WIDTH - 9);

  localparam logic [DATA_WIDTH-1:0] A90  = DATA_WIDTH'(ANGLE_90);
  localparam logic [DATA_WIDTH-1:0] A180 = DATA_WIDTH'(ANGLE_180);
  localparam logic [DATA_WIDTH-1:0] A270 = DATA_WIDTH'(ANGLE_270);
  localparam logic [DATA_WIDTH-1:0] A360 = DATA_WIDTH'(ANGLE_360);

  ar_state_e             state_q;
  logic [DATA_WIDTH-1:0] r_q;
  logic                  neg_q;
  logic [KW-1:0]         k_q;
  logic                  out_valid_q;
  logic [1:0]            quadrant_q;
  logic [DATA_WIDTH-1:0] angle_q;

  logic [DATA_WIDTH-1:0] sub_d;
  logic [DATA_WIDTH-1:0] r_step_d;
  logic [DATA_WIDTH-1:0] r_map_d;
  logic [1:0]            quadrant_d;
  logic [DATA_WIDTH-1:0] angle_d;

  assign in_ready  = (state_q == AR_IDLE) && !reset;
  assign out_valid = out_valid_q;
  assign quadrant  = quadrant_q;
  assign angle_out = angle_q;

  // One shift-subtract step, and the sign fold / quadrant map of the final remainder.
  // 360 << (DATA_WIDTH-9) always fits in DATA_WIDTH bits, so no guard bits are needed.
  always_comb begin
    sub_d      = A360 << k_q;
    r_step_d   = (r_q >= sub_d) ? (r_q - sub_d) : r_q;
    r_map_d    = (neg_q && (r_q != '0)) ? (A360 - r_q) : r_q;
    quadrant_d = 2'd0;
    angle_d    = r_map_d;
    if (r_map_d < A90) begin
      quadrant_d = 2'd0;
      angle_d    = r_map_d;
    end else if (r_map_d < A180) begin
      quadrant_d = 2'd1;
      angle_d    = A180 - r_map_d;
    end else if (r_map_d < A270) begin
      quadrant_d = 2'd2;
      angle_d    = r_map_d - A180;
    end else begin
      quadrant_d = 2'd3;
      angle_d    = A360 - r_map_d;
    end
  end

  // Control FSM: accept, fixed-length reduction, map, then hold result until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= AR_IDLE;
      r_q         <= '0;
      neg_q       <= 1'b0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      quadrant_q  <= 2'd0;
      angle_q     <= '0;
    end else begin
      case (state_q)
        AR_IDLE: begin
          if (in_valid && in_ready) begin
            r_q     <= angle_in;
            neg_q   <= angle_neg;
            k_q     <= K_INIT;
            state_q <= AR_REDUCE;
          end
        end
        AR_REDUCE: begin
          r_q <= r_step_d;
          if (k_q == '0) state_q <= AR_MAP;
          else           k_q     <= k_q - 1'b1;
        end
        AR_MAP: begin
          quadrant_q  <= quadrant_d;
          angle_q     <= angle_d;
          out_valid_q <= 1'b1;
          state_q     <= AR_DONE;
        end
        AR_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= AR_IDLE;
          end
        end
        default: state_q <= AR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_angle_reducer.sv
// Self-checking bench for angle_reducer at DATA_WIDTH=32.
module tb_angle_reducer;

  localparam int DW  = 32;
  localparam int LAT = DW - 8 + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] angle_in;
  logic          angle_neg;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    quadrant;
  logic [DW-1:0] angle_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  angle_reducer #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle_in  (angle_in),
    .angle_neg (angle_neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quadrant  (quadrant),
    .angle_out (angle_out)
  );

  typedef struct {
    logic [31:0] ang;
    logic        neg;
    logic [1:0]  q;
    logic [31:0] a;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: reduce with plain modulo, fold sign, then classify by range.
  task automatic model(input logic [31:0] ang, input logic neg,
                       output logic [1:0] q, output logic [31:0] a);
    longint unsigned m;
    m = longint'(ang) % 360;
    if (neg && m != 0) m = 360 - m;
    if (m < 90)       begin q = 2'd0; a = 32'(m);       end
    else if (m < 180) begin q = 2'd1; a = 32'(180 - m); end
    else if (m < 270) begin q = 2'd2; a = 32'(m - 180); end
    else              begin q = 2'd3; a = 32'(360 - m); end
  endtask

  // Present one angle, return result and edges from accept until out_valid seen.
  task automatic run_one(input logic [31:0] ang, input logic neg,
                         output logic [1:0] q, output logic [31:0] a, output int lat);
    int w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    in_valid = 1'b1; angle_in = ang; angle_neg = neg;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 60);
    q = quadrant; a = angle_out;
  endtask

  // Run one vector with out_ready held high and check result, latency, single-cycle valid.
  task automatic run_check(input string name, input logic [31:0] ang, input logic neg,
                           input logic [1:0] eq, input logic [31:0] ea);
    logic [1:0]  q;
    logic [31:0] a;
    int          lat;
    run_one(ang, neg, q, a, lat);
    chk({name, " latency"}, 64'(lat), 64'(LAT));
    chk({name, " quadrant"}, 64'(q), 64'(eq));
    chk({name, " angle"}, 64'(a), 64'(ea));
    @(posedge clk); #1;
    chk({name, " valid drop"}, 64'(out_valid), 64'd0);
    chk({name, " ready back"}, 64'(in_ready), 64'd1);
  endtask

  vec_t vt[10];

  initial begin
    logic [1:0]  q, mq;
    logic [31:0] a, ma, ang;
    logic        neg;
    int          lat;
    logic        seen;

    vt[0] = '{32'd45,         1'b0, 2'd0, 32'd45};
    vt[1] = '{32'd135,        1'b0, 2'd1, 32'd45};
    vt[2] = '{32'd270,        1'b0, 2'd3, 32'd90};
    vt[3] = '{32'd90,         1'b0, 2'd1, 32'd90};
    vt[4] = '{32'd180,        1'b0, 2'd2, 32'd0};
    vt[5] = '{32'd1000,       1'b0, 2'd3, 32'd80};
    vt[6] = '{32'hFFFF_FFFF,  1'b0, 2'd2, 32'd75};
    vt[7] = '{32'd30,         1'b1, 2'd3, 32'd30};
    vt[8] = '{32'd360,        1'b1, 2'd0, 32'd0};
    vt[9] = '{32'd450,        1'b1, 2'd3, 32'd90};

    reset = 1'b1; in_valid = 1'b0; angle_in = '0; angle_neg = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 64'(in_ready), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset quadrant", 64'(quadrant), 64'd0);
    chk("reset angle_out", 64'(angle_out), 64'd0);
    reset = 1'b0;
    #1;
    chk("post-reset in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 10; i++)
      run_check($sformatf("vec%0d", i), vt[i].ang, vt[i].neg, vt[i].q, vt[i].a);

    run_check("zero", 32'd0, 1'b0, 2'd0, 32'd0);
    run_check("negzero", 32'd0, 1'b1, 2'd0, 32'd0);

    // Backpressure: result must hold and inputs be ignored until out_ready.
    out_ready = 1'b0;
    run_one(32'd100, 1'b0, q, a, lat);
    chk("bp latency", 64'(lat), 64'(LAT));
    chk("bp quadrant", 64'(q), 64'd1);
    chk("bp angle", 64'(a), 64'd80);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2); angle_in = 32'd45; angle_neg = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("bp hold valid %0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("bp hold q %0d", i), 64'(quadrant), 64'd1);
      chk($sformatf("bp hold a %0d", i), 64'(angle_out), 64'd80);
      chk($sformatf("bp in_ready %0d", i), 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp retire valid", 64'(out_valid), 64'd0);
    chk("bp retire in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (30) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    chk("bp pulse ignored", 64'(seen), 64'd0);

    // Reset during REDUCE drops the operation.
    in_valid = 1'b1; angle_in = 32'd1000; angle_neg = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midreset in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("after reset in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (30) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    chk("aborted no valid", 64'(seen), 64'd0);
    run_check("after reset 200", 32'd200, 1'b0, 2'd2, 32'd20);

    // Randomized vectors against the reference model.
    for (int i = 0; i < 40; i++) begin
      case (i % 4)
        0: ang = $urandom;
        1: ang = $urandom_range(0, 1500);
        2: ang = 32'($urandom_range(0, 20)) * 32'd90 + 32'($urandom_range(0, 1));
        default: ang = 32'hFFFF_FFFF - 32'($urandom_range(0, 720));
      endcase
      neg = 1'($urandom);
      model(ang, neg, mq, ma);
      run_check($sformatf("rand%0d ang=%0d neg=%0d", i, ang, neg), ang, neg, mq, ma);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
